// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains fifo_sync one byte at a time and serialises each byte as an async UART frame.
// Define PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DONE_CNT = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] POP    = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
`ifdef PARITY_EN
    localparam logic [2:0] PARITY = 3'd5;
`endif
    localparam logic [2:0] STOP   = 3'd6;

    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] sh;
    logic                 wrap;
`ifdef PARITY_EN
    logic                 par;
`endif

    assign wrap       = cnt == LAST_CNT;
    assign fifo_rd_en = state == POP;
    assign busy       = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sh      <= '0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
`ifdef PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            // states from START onward are bit-timed; everything before runs with the counter held at 0
            cnt     <= (state >= START && !wrap) ? cnt + 1'b1 : '0;
            tx_done <= state == STOP && cnt == DONE_CNT;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo_empty) state <= POP;
                end
                POP: state <= WAIT;
                WAIT: begin
                    sh    <= fifo_data;
                    idx   <= '0;
                    tx    <= 1'b0;
                    state <= START;
`ifdef PARITY_EN
                    par   <= ^fifo_data;
`endif
                end
                START: if (wrap) begin
                    tx    <= sh[0];
                    sh    <= sh >> 1;
                    state <= DATA;
                end
                DATA: if (wrap) begin
                    if (idx == LAST_BIT) begin
`ifdef PARITY_EN
                        tx    <= par;
                        state <= PARITY;
`else
                        tx    <= 1'b1;
                        state <= STOP;
`endif
                    end else begin
                        tx  <= sh[0];
                        sh  <= sh >> 1;
                        idx <= idx + 1'b1;
                    end
                end
`ifdef PARITY_EN
                PARITY: if (wrap) begin
                    tx    <= 1'b1;
                    state <= STOP;
                end
`endif
                STOP: if (wrap) state <= IDLE;
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx at 4 clks/bit with a small behavioural FIFO
// standing in for fifo_sync (registered data_out, valid the cycle after rd_en).
module tb_fifo_uart_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en, tx, busy, tx_done;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] mem [0:15];
    int         wp = 0, rp = 0, fcnt = 0;
    int         rd_seen = 0, done_seen = 0;
    int         passed = 0, total = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = fcnt == 0;

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wp % 16] <= wr_data;
            wp <= wp + 1;
        end
        if (fifo_rd_en && fcnt > 0) begin
            fifo_data <= mem[rp % 16];
            rp <= rp + 1;
        end
        fcnt <= fcnt + (wr_en ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (fifo_rd_en === 1'b1) rd_seen++;
        if (tx_done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Waits for the start bit, then checks every sample of the frame; drop_at >= 0 clears enable
    // partway through that data bit. gap returns the idle-high samples seen before the start bit.
    task automatic expect_frame(input logic [7:0] b, input int drop_at, output int gap);
        logic [10:0] bits;
        int n;
`ifdef PARITY_EN
        n = 11;
        bits = {1'b1, ^b, b, 1'b0};
`else
        n = 10;
        bits = {1'b0, 1'b1, b, 1'b0};
`endif
        gap = 0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < 200) begin
            gap++;
            @(negedge clk);
        end
        check("start_found", tx, 1'b0);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i > 0 || j > 0) @(negedge clk);
                if (drop_at >= 0 && i == drop_at + 1 && j == 1) enable = 1'b0;
                check($sformatf("tx_%02h_bit%0d_s%0d", b, i, j), tx, bits[i]);
                check("busy_in_frame", busy, 1'b1);
                check($sformatf("tx_done_bit%0d_s%0d", i, j), tx_done, (i == n - 1 && j == 3));
            end
        end
    endtask

    initial begin
        int g, r0, d0;
        // 1: reset held, then released with the FIFO empty
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", tx, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_rd_en", fifo_rd_en, 1'b0);
            check("rst_tx_done", tx_done, 1'b0);
        end
        reset = 1'b1;
        enable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("empty_tx", tx, 1'b1);
            check("empty_busy", busy, 1'b0);
            check("empty_rd_en", fifo_rd_en, 1'b0);
        end
        // 2: single byte 0xA5
        r0 = rd_seen;
        d0 = done_seen;
        push(8'hA5);
        expect_frame(8'hA5, -1, g);
        @(negedge clk);
        check("a5_busy_after", busy, 1'b0);
        check("a5_rd_pulses", rd_seen - r0, 1);
        check("a5_done_pulses", done_seen - d0, 1);
        // 3: eight bytes back to back
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(i));
        r0 = rd_seen;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_frame(8'(i), -1, g);
            if (i > 0) check($sformatf("gap_before_%0d", i), g, 3);
        end
        @(negedge clk);
        check("burst_rd_pulses", rd_seen - r0, 8);
        check("burst_empty", fifo_empty, 1'b1);
        check("burst_busy", busy, 1'b0);
        // 4: enable low holds off; dropping it mid-frame lets that frame finish
        enable = 1'b0;
        push(8'h3C);
        push(8'hC3);
        repeat (8) begin
            @(negedge clk);
            check("hold_tx", tx, 1'b1);
            check("hold_rd_en", fifo_rd_en, 1'b0);
        end
        r0 = rd_seen;
        enable = 1'b1;
        expect_frame(8'h3C, 2, g);
        repeat (10) begin
            @(negedge clk);
            check("dropped_tx", tx, 1'b1);
            check("dropped_busy", busy, 1'b0);
        end
        check("dropped_rd_pulses", rd_seen - r0, 1);
        check("dropped_left", fcnt, 1);
        // 5: reset during data bit 3 of 0xC3, then a fresh frame for 0x5A
        push(8'h5A);
        enable = 1'b1;
        g = 0;
        @(negedge clk);
        while (tx !== 1'b0 && g < 200) begin
            g++;
            @(negedge clk);
        end
        check("c3_start", tx, 1'b0);
        repeat (18) @(negedge clk);
        check("c3_bit3", tx, 1'b0);
        #1 reset = 1'b0;
        #1;
        check("async_rst_tx", tx, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        check("held_rst_tx", tx, 1'b1);
        check("held_rst_left", fcnt, 1);
        r0 = rd_seen;
        reset = 1'b1;
        expect_frame(8'h5A, -1, g);
        check("post_rst_rd_pulses", rd_seen - r0, 1);
        check("post_rst_empty", fifo_empty, 1'b1);
`ifdef PARITY_EN
        // 6: parity frames, 44 clks each
        push(8'h07);
        expect_frame(8'h07, -1, g);
        push(8'h03);
        expect_frame(8'h03, -1, g);
`endif
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
